// File: rtl/ahb_matrix_pkg.sv
// Shared AHB-Lite matrix encodings: transfer types, responses, default-slave select and FSM states.
// Also hosts the address-phase one-hot to index priority encoder.
package ahb_matrix_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] DEF_SLV_SEL = 3'd4;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } def_slv_state_t;

  // Lowest set bit wins; an all-zero select maps to the default slave.
  function automatic logic [2:0] encode_hsel(input logic [3:0] hsel);
    logic [2:0] sel;
    casez (hsel)
      4'b???1: sel = 3'd0;
      4'b??10: sel = 3'd1;
      4'b?100: sel = 3'd2;
      4'b1000: sel = 3'd3;
      default: sel = DEF_SLV_SEL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped space: two-cycle ERROR for active transfers, zero-wait OKAY otherwise.
// Outputs are pure state decode; advances only on HREADY-qualified address phases.
module ahb_default_slave
  import ahb_matrix_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADY,
  input  logic       hit_default,
  input  logic [1:0] HTRANS,
  output logic       HREADYOUT,
  output logic       HRESP
);

  def_slv_state_t state, state_nxt;
  logic           trans_active;
  logic           err_start;

  assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign err_start    = HREADY && hit_default && trans_active;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= DS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      DS_IDLE: begin
        if (err_start) state_nxt = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        // Second error cycle is also the next address phase, so errors can chain.
        HRESP     = HRESP_ERROR;
        state_nxt = err_start ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/s2m_resp_mux.sv
// AHB-Lite slave-to-master response mux: registers the address-phase select, routes slave responses back.
// One cycle address-to-data select latency, zero from slave inputs; select holds through HREADY=0 wait states.
module s2m_resp_mux
  import ahb_matrix_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NSLV = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [3:0]    HSEL_A,
  input  logic [1:0]    HTRANS,
  input  logic [DW-1:0] S0_HRDATA,
  input  logic [DW-1:0] S1_HRDATA,
  input  logic [DW-1:0] S2_HRDATA,
  input  logic [DW-1:0] S3_HRDATA,
  input  logic          S0_HREADYOUT,
  input  logic          S1_HREADYOUT,
  input  logic          S2_HREADYOUT,
  input  logic          S3_HREADYOUT,
  input  logic          S0_HRESP,
  input  logic          S1_HRESP,
  input  logic          S2_HRESP,
  input  logic          S3_HRESP,
  output logic [DW-1:0] HRDATA,
  output logic          HREADY,
  output logic          HRESP,
  output logic [2:0]    Slave_Sel_D
);

  logic [DW-1:0] s_rdata [NSLV];
  logic          s_ready [NSLV];
  logic          s_resp  [NSLV];
  logic [2:0]    sel_a;
  logic          def_hreadyout;
  logic          def_hresp;

  assign s_rdata[0] = S0_HRDATA;
  assign s_rdata[1] = S1_HRDATA;
  assign s_rdata[2] = S2_HRDATA;
  assign s_rdata[3] = S3_HRDATA;
  assign s_ready[0] = S0_HREADYOUT;
  assign s_ready[1] = S1_HREADYOUT;
  assign s_ready[2] = S2_HREADYOUT;
  assign s_ready[3] = S3_HREADYOUT;
  assign s_resp[0]  = S0_HRESP;
  assign s_resp[1]  = S1_HRESP;
  assign s_resp[2]  = S2_HRESP;
  assign s_resp[3]  = S3_HRESP;

  assign sel_a = encode_hsel(HSEL_A);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      Slave_Sel_D <= DEF_SLV_SEL;
    else if (HREADY) Slave_Sel_D <= sel_a;
  end

  ahb_default_slave u_def_slv (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HREADY      (HREADY),
    .hit_default (sel_a == DEF_SLV_SEL),
    .HTRANS      (HTRANS),
    .HREADYOUT   (def_hreadyout),
    .HRESP       (def_hresp)
  );

  // Any select with bit 2 set (only 4 is reachable) is served by the default slave.
  always_comb begin
    HRDATA = '0;
    HREADY = def_hreadyout;
    HRESP  = def_hresp;
    if (!Slave_Sel_D[2]) begin
      HRDATA = s_rdata[Slave_Sel_D[1:0]];
      HREADY = s_ready[Slave_Sel_D[1:0]];
      HRESP  = s_resp[Slave_Sel_D[1:0]];
    end
  end

endmodule

// File: tb/tb_s2m_resp_mux.sv
// Directed bench for s2m_resp_mux: reset, routing, wait states, default-slave errors, multi-hot priority.
module tb_s2m_resp_mux;
  import ahb_matrix_pkg::*;

  localparam int DW = 32;

  logic          HCLK;
  logic          HRESET;
  logic [3:0]    HSEL_A;
  logic [1:0]    HTRANS;
  logic [DW-1:0] S0_HRDATA, S1_HRDATA, S2_HRDATA, S3_HRDATA;
  logic          S0_HREADYOUT, S1_HREADYOUT, S2_HREADYOUT, S3_HREADYOUT;
  logic          S0_HRESP, S1_HRESP, S2_HRESP, S3_HRESP;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic [2:0]    Slave_Sel_D;

  int tests = 0;
  int fails = 0;

  s2m_resp_mux #(.DW(DW), .NSLV(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_A(HSEL_A), .HTRANS(HTRANS),
    .S0_HRDATA(S0_HRDATA), .S1_HRDATA(S1_HRDATA), .S2_HRDATA(S2_HRDATA), .S3_HRDATA(S3_HRDATA),
    .S0_HREADYOUT(S0_HREADYOUT), .S1_HREADYOUT(S1_HREADYOUT),
    .S2_HREADYOUT(S2_HREADYOUT), .S3_HREADYOUT(S3_HREADYOUT),
    .S0_HRESP(S0_HRESP), .S1_HRESP(S1_HRESP), .S2_HRESP(S2_HRESP), .S3_HRESP(S3_HRESP),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .Slave_Sel_D(Slave_Sel_D)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance past one rising edge; inputs change and outputs are sampled away from it.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    HSEL_A = 4'b0000;
    HTRANS = HTRANS_IDLE;
    S0_HRDATA = 32'h0000_A000; S1_HRDATA = 32'h1111_1111;
    S2_HRDATA = 32'hDEAD_BEEF; S3_HRDATA = 32'h3333_3333;
    S0_HREADYOUT = 1'b1; S1_HREADYOUT = 1'b1; S2_HREADYOUT = 1'b1; S3_HREADYOUT = 1'b1;
    S0_HRESP = 1'b0; S1_HRESP = 1'b0; S2_HRESP = 1'b0; S3_HRESP = 1'b0;
    #3;
    tests++;
    if (Slave_Sel_D !== 3'd4) begin fails++; $display("FAIL reset_sel: got %0d exp 4", Slave_Sel_D); end
    tests++;
    if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL reset_rdy_resp: got %b exp 10", {HREADY, HRESP}); end
    tests++;
    if (HRDATA !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h exp 0", HRDATA); end
    tick();
    tick();
    #2 HRESET = 1'b0;
  endtask

  task automatic test_basic_read();
    HSEL_A = 4'b0100; HTRANS = HTRANS_NONSEQ;
    tick();
    HSEL_A = 4'b0000; HTRANS = HTRANS_IDLE;
    #1;
    tests++;
    if (Slave_Sel_D !== 3'd2) begin fails++; $display("FAIL read_sel: got %0d exp 2", Slave_Sel_D); end
    tests++;
    if (HRDATA !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_rdata: got %h exp deadbeef", HRDATA); end
    tests++;
    if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL read_rdy_resp: got %b exp 10", {HREADY, HRESP}); end
    tick();
  endtask

  task automatic test_wait_states();
    HSEL_A = 4'b0010; HTRANS = HTRANS_NONSEQ;
    tick();
    S1_HREADYOUT = 1'b0;
    HSEL_A = 4'b1000; HTRANS = HTRANS_NONSEQ;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({Slave_Sel_D, HREADY} !== {3'd1, 1'b0})
        begin fails++; $display("FAIL wait_hold[%0d]: got sel=%0d rdy=%b exp sel=1 rdy=0", i, Slave_Sel_D, HREADY); end
      if (i < 2) tick();
    end
    S1_HREADYOUT = 1'b1;
    #1;
    tests++;
    if ({Slave_Sel_D, HREADY, HRDATA} !== {3'd1, 1'b1, 32'h1111_1111})
      begin fails++; $display("FAIL wait_release: got sel=%0d rdy=%b data=%h exp sel=1 rdy=1 data=11111111", Slave_Sel_D, HREADY, HRDATA); end
    tick();
    HSEL_A = 4'b0000; HTRANS = HTRANS_IDLE;
    #1;
    tests++;
    if ({Slave_Sel_D, HRDATA} !== {3'd3, 32'h3333_3333})
      begin fails++; $display("FAIL wait_next_sel: got sel=%0d data=%h exp sel=3 data=33333333", Slave_Sel_D, HRDATA); end
    tick();
  endtask

  task automatic test_unmapped();
    logic [1:0] exp_rr [3];
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b11; exp_rr[2] = 2'b10;
    HSEL_A = 4'b0000; HTRANS = HTRANS_NONSEQ;
    tick();
    HTRANS = HTRANS_IDLE;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({Slave_Sel_D, HREADY, HRESP, HRDATA} !== {3'd4, exp_rr[i], 32'h0})
        begin fails++; $display("FAIL unmapped[%0d]: got sel=%0d rdy/resp=%b data=%h exp sel=4 rdy/resp=%b data=0", i, Slave_Sel_D, {HREADY, HRESP}, HRDATA, exp_rr[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rr [6];
    logic [1:0] trans [6];
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b11; exp_rr[2] = 2'b01;
    exp_rr[3] = 2'b11; exp_rr[4] = 2'b10; exp_rr[5] = 2'b10;
    trans[0] = HTRANS_SEQ;  trans[1] = HTRANS_SEQ;  trans[2] = HTRANS_IDLE;
    trans[3] = HTRANS_IDLE; trans[4] = HTRANS_BUSY; trans[5] = HTRANS_IDLE;
    HSEL_A = 4'b0000; HTRANS = HTRANS_NONSEQ;
    tick();
    for (int i = 0; i < 6; i++) begin
      HTRANS = trans[i];
      #1;
      tests++;
      if ({HREADY, HRESP} !== exp_rr[i])
        begin fails++; $display("FAIL b2b[%0d]: got rdy/resp=%b exp %b", i, {HREADY, HRESP}, exp_rr[i]); end
      tick();
    end
  endtask

  task automatic test_multi_hot();
    HSEL_A = 4'b0110; HTRANS = HTRANS_NONSEQ; S1_HRESP = 1'b1;
    tick();
    HSEL_A = 4'b1100;
    #1;
    tests++;
    if ({Slave_Sel_D, HRDATA, HREADY, HRESP} !== {3'd1, 32'h1111_1111, 1'b1, 1'b1})
      begin fails++; $display("FAIL multihot_0110: got sel=%0d data=%h rdy=%b resp=%b exp sel=1 data=11111111 rdy=1 resp=1", Slave_Sel_D, HRDATA, HREADY, HRESP); end
    tick();
    S1_HRESP = 1'b0;
    HSEL_A = 4'b1111;
    #1;
    tests++;
    if ({Slave_Sel_D, HRDATA} !== {3'd2, 32'hDEAD_BEEF})
      begin fails++; $display("FAIL multihot_1100: got sel=%0d data=%h exp sel=2 data=deadbeef", Slave_Sel_D, HRDATA); end
    tick();
    HSEL_A = 4'b0000; HTRANS = HTRANS_IDLE;
    #1;
    tests++;
    if ({Slave_Sel_D, HRDATA} !== {3'd0, 32'h0000_A000})
      begin fails++; $display("FAIL multihot_1111: got sel=%0d data=%h exp sel=0 data=0000a000", Slave_Sel_D, HRDATA); end
    tick();
  endtask

  task automatic test_mid_reset();
    HSEL_A = 4'b0010; HTRANS = HTRANS_NONSEQ;
    tick();
    S1_HREADYOUT = 1'b0;
    HSEL_A = 4'b0000; HTRANS = HTRANS_IDLE;
    #1;
    tests++;
    if ({Slave_Sel_D, HREADY} !== {3'd1, 1'b0})
      begin fails++; $display("FAIL midrst_pre: got sel=%0d rdy=%b exp sel=1 rdy=0", Slave_Sel_D, HREADY); end
    #1 HRESET = 1'b1;
    #1;
    tests++;
    if ({Slave_Sel_D, HREADY, HRESP, HRDATA} !== {3'd4, 1'b1, 1'b0, 32'h0})
      begin fails++; $display("FAIL midrst_wait: got sel=%0d rdy=%b resp=%b data=%h exp sel=4 rdy=1 resp=0 data=0", Slave_Sel_D, HREADY, HRESP, HRDATA); end
    S1_HREADYOUT = 1'b1;
    tick();
    #2 HRESET = 1'b0;
    // Abort an error in progress: enter ERR1, reset, then confirm the FSM restarted from IDLE.
    HTRANS = HTRANS_NONSEQ;
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    tests++;
    if ({HREADY, HRESP} !== 2'b01) begin fails++; $display("FAIL midrst_err1: got %b exp 01", {HREADY, HRESP}); end
    #1 HRESET = 1'b1;
    #1;
    tests++;
    if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL midrst_err_async: got %b exp 10", {HREADY, HRESP}); end
    #1 HRESET = 1'b0;
    tick();
    tests++;
    if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL midrst_fsm_idle: got %b exp 10", {HREADY, HRESP}); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_wait_states();
    test_unmapped();
    test_back_to_back();
    test_multi_hot();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
